// File: rtl/circ_fifo.sv
// circ_fifo: synchronous circular-buffer FIFO with occupancy flags and
// sticky overflow/underflow error flags.
// Optional feature macro: CIRC_FIFO_FWFT_EN.
//   Undefined (default): registered read. read_data loads on an accepted pop
//                        and read_valid pulses for the following cycle.
//   Defined:             first-word-fall-through. The head entry is shown
//                        combinationally and read_en pops it.
module circ_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     write_en,
   input  logic [WIDTH-1:0]         write_data,
   input  logic                     read_en,
   output logic [WIDTH-1:0]         read_data,
   output logic                     read_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

   // Pointers carry one wrap bit above the index, so full and empty can be told apart.
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_acc;
   logic             rd_acc;

   // Status comes only from registered pointers, so there is no path from write_en/read_en.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (count >= AF_LIM);
   assign almost_empty = (count <= AE_LIM);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // Flush overrides both requests. A rejected request only updates the error flags.
   assign wr_acc = write_en && !full && !flush;
   assign rd_acc = read_en && !empty && !flush;

   // Next-state logic for the pointers and the sticky error flags.
   always_comb begin
      // NOTE: each _d gets its hold value first, so a missed branch cannot infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_acc)              wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_acc)              rd_ptr_d = rd_ptr_q + PW'(1);
         if (write_en && full)    ovf_d    = 1'b1;
         if (read_en && empty)    unf_d    = 1'b1;
      end
   end

   // Pointer and flag registers. Reset has priority over every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array written at the write index on an accepted push.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset. The pointers alone decide which entries are live.
      if (!reset && wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= write_data;
   end

`ifdef CIRC_FIFO_FWFT_EN
   // Head entry falls through. It shows zero while empty, so reset reads back 0.
   assign read_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign read_valid = !empty;
`else
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;

   // Capture the head on an accepted pop. Otherwise hold the last value.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_acc;
      if (rd_acc) rdata_d = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Registered read port. read_valid is a one-cycle pulse after each pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign read_data  = rdata_q;
   assign read_valid = rvalid_q;
`endif

endmodule

// File: tb/tb_circ_fifo.sv
// Self-checking bench for circ_fifo (DEPTH=8, WIDTH=32, default thresholds).
// It uses a directed vector table, hand sequences for the corner cases, and
// a randomized run against a queue-based model.
module tb_circ_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             reset, flush, write_en, read_en;
   logic [WIDTH-1:0] write_data;
   logic [WIDTH-1:0] read_data;
   logic             read_valid, full, empty, almost_full, almost_empty;
   logic [3:0]       count;
   logic             overflow, underflow;

   int checks = 0;
   int errors = 0;

   // Model state: contents in push order, sticky flags and the read port.
   logic [WIDTH-1:0] mq[$];
   bit               m_ov, m_un, m_rv;
   logic [WIDTH-1:0] m_rd;

   circ_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .write_en(write_en),
      .write_data(write_data), .read_en(read_en), .read_data(read_data),
      .read_valid(read_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Compare every output with the model.
   task automatic cmp_model(input string tag);
      int n;
      n = mq.size();
      check({tag, ".count"},  32'(count),        32'(n));
      check({tag, ".full"},   32'(full),         32'(n == DEPTH));
      check({tag, ".empty"},  32'(empty),        32'(n == 0));
      check({tag, ".af"},     32'(almost_full),  32'(n >= DEPTH - 1));
      check({tag, ".ae"},     32'(almost_empty), 32'(n <= 1));
      check({tag, ".ovf"},    32'(overflow),     32'(m_ov));
      check({tag, ".unf"},    32'(underflow),    32'(m_un));
`ifdef CIRC_FIFO_FWFT_EN
      check({tag, ".rvalid"}, 32'(read_valid),   32'(n != 0));
      check({tag, ".rdata"},  read_data,         (n != 0) ? mq[0] : 32'h0);
`else
      check({tag, ".rvalid"}, 32'(read_valid),   32'(m_rv));
      check({tag, ".rdata"},  read_data,         m_rd);
`endif
   endtask

   // Drive one cycle of inputs, clock it, step the model and compare.
   task automatic apply(input string tag, input bit r, input bit f, input bit w,
                        input bit rr, input logic [WIDTH-1:0] d);
      int n;
      reset = r; flush = f; write_en = w; read_en = rr; write_data = d;
      @(posedge clk);
      #1;
      n = mq.size();
      if (r) begin
         mq.delete(); m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;
      end else if (f) begin
         mq.delete(); m_ov = 0; m_un = 0; m_rv = 0;
      end else begin
         if (w && n == DEPTH) m_ov = 1;
         if (rr && n == 0)    m_un = 1;
         m_rv = 0;
         if (rr && n > 0) begin
            m_rd = mq.pop_front();
            m_rv = 1;
         end
         if (w && n < DEPTH) mq.push_back(d);
      end
      cmp_model(tag);
      reset = 0; flush = 0; write_en = 0; read_en = 0;
   endtask

   typedef struct {
      bit          rst, fl, we, re;
      logic [31:0] wd;
      int          exp_cnt;
      bit          exp_empty, exp_ov, exp_un, exp_rv;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[12];

   initial begin
      reset = 1; flush = 0; write_en = 0; read_en = 0; write_data = '0;
      m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;

      // Directed vectors: {rst, fl, we, re, wd, cnt, empty, ovf, unf, rvalid, rdata}
      vecs[0]  = '{1, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0, 32'h00};
      vecs[1]  = '{0, 0, 1, 0, 32'h11, 1, 0, 0, 0, 0, 32'h00};
      vecs[2]  = '{0, 0, 1, 0, 32'h22, 2, 0, 0, 0, 0, 32'h00};
      vecs[3]  = '{0, 0, 0, 1, 32'h00, 1, 0, 0, 0, 1, 32'h11};
      vecs[4]  = '{0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 32'h11};
      vecs[5]  = '{0, 0, 1, 1, 32'h33, 1, 0, 0, 0, 1, 32'h22};
      vecs[6]  = '{0, 0, 0, 1, 32'h00, 0, 1, 0, 0, 1, 32'h33};
      vecs[7]  = '{0, 0, 0, 1, 32'h00, 0, 1, 0, 1, 0, 32'h33};
      vecs[8]  = '{0, 1, 0, 0, 32'h00, 0, 1, 0, 0, 0, 32'h33};
      vecs[9]  = '{0, 1, 1, 0, 32'h44, 0, 1, 0, 0, 0, 32'h33};
      vecs[10] = '{0, 0, 1, 0, 32'h55, 1, 0, 0, 0, 0, 32'h33};
      vecs[11] = '{1, 0, 1, 0, 32'h66, 0, 1, 0, 0, 0, 32'h00};

      foreach (vecs[i]) begin
         apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].fl, vecs[i].we, vecs[i].re, vecs[i].wd);
         check($sformatf("vec%0d.tcount", i), 32'(count),     32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d.tempty", i), 32'(empty),     32'(vecs[i].exp_empty));
         check($sformatf("vec%0d.tovf", i),   32'(overflow),  32'(vecs[i].exp_ov));
         check($sformatf("vec%0d.tunf", i),   32'(underflow), 32'(vecs[i].exp_un));
`ifndef CIRC_FIFO_FWFT_EN
         check($sformatf("vec%0d.trv", i),    32'(read_valid), 32'(vecs[i].exp_rv));
         check($sformatf("vec%0d.trd", i),    read_data,       vecs[i].exp_rd);
`endif
      end

      // Reset state with the default thresholds.
      apply("rst", 1, 0, 0, 0, 0);
      check("rst.almost_empty", 32'(almost_empty), 32'd1);
      check("rst.almost_full",  32'(almost_full),  32'd0);
      check("rst.read_data",    read_data,         32'd0);

      // Fill: write 0..10. The 8th write fills the FIFO and 8..10 are dropped.
      for (int i = 0; i <= 10; i++) begin
         apply($sformatf("fill%0d", i), 0, 0, 1, 0, 32'(i));
         if (i == 7) begin
            check("fill.full8",  32'(full),  32'd1);
            check("fill.count8", 32'(count), 32'd8);
         end
      end
      check("fill.overflow", 32'(overflow), 32'd1);
      check("fill.count",    32'(count),    32'd8);

      // Drain: nine pops return 0..7 in order, then the ninth request underflows.
      for (int i = 0; i < 9; i++) begin
`ifdef CIRC_FIFO_FWFT_EN
         if (i < 8) check($sformatf("drain.head%0d", i), read_data, 32'(i));
`endif
         apply($sformatf("drain%0d", i), 0, 0, 0, 1, 0);
`ifndef CIRC_FIFO_FWFT_EN
         if (i < 8) check($sformatf("drain.rd%0d", i), read_data, 32'(i));
`endif
      end
      check("drain.empty",     32'(empty),     32'd1);
      check("drain.count",     32'(count),     32'd0);
      check("drain.underflow", 32'(underflow), 32'd1);

      // Wrap: hold occupancy at 3 for 20 push/pop pairs (23 pushes wrap pointers twice).
      apply("wrap.rst", 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) apply("wrap.pre", 0, 0, 1, 0, 32'(100 + i));
      for (int k = 0; k < 20; k++) begin
`ifdef CIRC_FIFO_FWFT_EN
         check($sformatf("wrap.head%0d", k), read_data, 32'(100 + k));
`endif
         apply($sformatf("wrap%0d", k), 0, 0, 1, 1, 32'(103 + k));
`ifndef CIRC_FIFO_FWFT_EN
         check($sformatf("wrap.rd%0d", k), read_data, 32'(100 + k));
`endif
         check($sformatf("wrap.count%0d", k), 32'(count), 32'd3);
      end
      check("wrap.ovf", 32'(overflow),  32'd0);
      check("wrap.unf", 32'(underflow), 32'd0);

      // Simultaneous push/pop when full: the pop is accepted, the push is rejected.
      apply("sim.rst", 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) apply("sim.fill", 0, 0, 1, 0, 32'(200 + i));
      apply("sim.full", 0, 0, 1, 1, 32'hAA);
      check("sim.full.count", 32'(count),    32'd7);
      check("sim.full.ovf",   32'(overflow), 32'd1);
      // Simultaneous push/pop at count 4: occupancy does not change.
      apply("sim.rst2", 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) apply("sim.fill4", 0, 0, 1, 0, 32'(300 + i));
      apply("sim.mid", 0, 0, 1, 1, 32'hAA);
      check("sim.mid.count", 32'(count), 32'd4);

      // Flush at count 5 with overflow set and a write pending.
      apply("fl.rst", 1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) apply("fl.fill", 0, 0, 1, 0, 32'(400 + i));
      for (int i = 0; i < 3; i++) apply("fl.pop", 0, 0, 0, 1, 0);
      check("fl.pre.count", 32'(count),    32'd5);
      check("fl.pre.ovf",   32'(overflow), 32'd1);
      apply("fl.flush", 0, 1, 1, 0, 32'hDEAD);
      check("fl.count", 32'(count),      32'd0);
      check("fl.empty", 32'(empty),      32'd1);
      check("fl.ovf",   32'(overflow),   32'd0);
      check("fl.rv",    32'(read_valid), 32'd0);
      // Reset during a write returns every output to its reset value.
      for (int i = 0; i < 6; i++) apply("rm.fill", 0, 0, 1, 0, 32'(500 + i));
      apply("rm.pop", 0, 0, 0, 1, 0);
      apply("rm.reset", 1, 0, 1, 1, 32'hBEEF);
      check("rm.count", 32'(count),      32'd0);
      check("rm.empty", 32'(empty),      32'd1);
      check("rm.rd",    read_data,       32'd0);
      check("rm.rv",    32'(read_valid), 32'd0);

      // Read-mode behaviour after a single write of 0x55.
      apply("mode.write", 0, 0, 1, 0, 32'h55);
`ifdef CIRC_FIFO_FWFT_EN
      check("mode.fwft.rd", read_data,       32'h55);
      check("mode.fwft.rv", 32'(read_valid), 32'd1);
`else
      check("mode.reg.idle.rv", 32'(read_valid), 32'd0);
      apply("mode.read", 0, 0, 0, 1, 0);
      check("mode.reg.rv", 32'(read_valid), 32'd1);
      check("mode.reg.rd", read_data,       32'h55);
      apply("mode.after", 0, 0, 0, 0, 0);
      check("mode.reg.pulse", 32'(read_valid), 32'd0);
`endif

      // Random traffic with shifting write/read bias against the queue model.
      begin
         int wb, rb;
         wb = 50; rb = 50;
         for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) begin
               wb = $urandom_range(10, 90);
               rb = $urandom_range(10, 90);
            end
            apply("rand",
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 99) < wb,
                  $urandom_range(0, 99) < rb,
                  $urandom);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
